// File: rtl/swan_block_loader_if.sv
// Byte-stream in / split-block out handshake bundle for the SWAN-64 input loader.
// Carries the byte intake (in_*), the block output (out_*), and the short-frame pulse.
// Modports: slave = loader side, master = byte source plus block consumer (environment).
interface swan_block_loader_if #(
  parameter int SIDE_SIZE = 32
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [7:0]           in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [0:SIDE_SIZE-1] out_left;   // bit 0 is the MSB, as the theta stage expects
  logic [0:SIDE_SIZE-1] out_right;
  logic                 frame_err;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_left, out_right, frame_err
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_left, out_right, frame_err
  );
endinterface

// File: rtl/swan_block_loader.sv
// Purpose: assembles 8 accepted bytes into one 64-bit block, presented as left/right 32-bit halves.
// Latency: block is on the output the cycle after its 8th byte when the output register is free.
// Backpressure: one held output block plus one pending block; in_ready drops only while a block is pending.
//
// Ports: clk, rst (synchronous, active-high); bus (swan_block_loader_if.slave) carrying
//   in_valid/in_ready/in_data/in_last, out_valid/out_ready/out_left/out_right and frame_err.
// Build option: define SWAN_LOADER_BE_EN for big-endian byte placement within each half;
//   the default build places bytes little-endian. Handshake and timing are identical.
module swan_block_loader #(
  parameter int BLOCK_SIZE = 64,
  parameter int SIDE_SIZE  = BLOCK_SIZE / 2,
  parameter int NBYTES     = BLOCK_SIZE / 8
) (
  input logic                clk,
  input logic                rst,
  swan_block_loader_if.slave bus
);

  localparam int HBYTES = NBYTES / 2;

  // Assembly state: cnt counts buffered bytes; 8 means a complete block is pending.
  logic [3:0]           cnt_q, cnt_d;
  logic [7:0]           byte_q [NBYTES];
  logic [7:0]           byte_d [NBYTES];

  // Output holding register.
  logic                 out_valid_q, out_valid_d;
  logic [SIDE_SIZE-1:0] out_left_q, out_left_d;
  logic [SIDE_SIZE-1:0] out_right_q, out_right_d;
  logic                 frame_err_q, frame_err_d;

  logic                 in_ready;
  logic                 accept;
  logic                 out_free;
  logic                 load;
  logic [SIDE_SIZE-1:0] asm_left, asm_right;

  // Ready depends only on state, so a source may sample it before deciding to drive valid.
  assign in_ready = (cnt_q != 4'd8);
  assign accept   = bus.in_valid && in_ready;
  // The output register can take a new block if empty or being consumed this cycle.
  assign out_free = !out_valid_q || bus.out_ready;

  // Byte buffer: the incoming byte lands at its slot; cnt is below 8 whenever accept is high.
  always_comb begin
    for (int k = 0; k < NBYTES; k++) begin
      byte_d[k] = byte_q[k];
    end
    if (accept) begin
      byte_d[cnt_q[2:0]] = bus.in_data;
    end
  end

  // Block assembly from the next-state buffer, so the 8th byte can be loaded at its own edge.
  always_comb begin
    asm_left  = '0;
    asm_right = '0;
    for (int k = 0; k < HBYTES; k++) begin
`ifdef SWAN_LOADER_BE_EN
      asm_left [SIDE_SIZE-8-8*k +: 8] = byte_d[k];
      asm_right[SIDE_SIZE-8-8*k +: 8] = byte_d[k+HBYTES];
`else
      asm_left [8*k +: 8] = byte_d[k];
      asm_right[8*k +: 8] = byte_d[k+HBYTES];
`endif
    end
  end

  // Counter, completion, short-frame drop and output register control.
  always_comb begin
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    frame_err_d = 1'b0;
    load        = 1'b0;

    if (accept) begin
      if (cnt_q == 4'd7) begin
        // in_last is irrelevant on the completing byte.
        if (out_free) begin
          load  = 1'b1;
          cnt_d = 4'd0;
        end else begin
          cnt_d = 4'd8;
        end
      end else if (bus.in_last) begin
        // Short frame: drop the partial block; the stale bytes are overwritten later.
        cnt_d       = 4'd0;
        frame_err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end else if ((cnt_q == 4'd8) && out_free) begin
      load  = 1'b1;
      cnt_d = 4'd0;
    end

    if (load) begin
      // A load during a consume replaces the old block with no bubble.
      out_valid_d = 1'b1;
      out_left_d  = asm_left;
      out_right_d = asm_right;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= 4'd0;
      out_valid_q <= 1'b0;
      out_left_q  <= '0;
      out_right_q <= '0;
      frame_err_q <= 1'b0;
      for (int k = 0; k < NBYTES; k++) begin
        byte_q[k] <= 8'h00;
      end
    end else begin
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      frame_err_q <= frame_err_d;
      for (int k = 0; k < NBYTES; k++) begin
        byte_q[k] <= byte_d[k];
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_left  = out_left_q;
  assign bus.out_right = out_right_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_swan_block_loader.sv
// Directed plus randomized bench for swan_block_loader against a queue-based reference model.
module tb_swan_block_loader;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  swan_block_loader_if #(.SIDE_SIZE(32)) bus ();

  swan_block_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: bytes waiting for a block, plus the visible output register.
  logic [7:0]  m_bytes [$];
  logic        m_oval;
  logic [31:0] m_left, m_right;
  logic        m_ferr;

  function automatic logic [31:0] pack_half(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3);
`ifdef SWAN_LOADER_BE_EN
    return (32'(b0) << 24) | (32'(b1) << 16) | (32'(b2) << 8) | 32'(b3);
`else
    return 32'(b0) | (32'(b1) << 8) | (32'(b2) << 16) | (32'(b3) << 24);
`endif
  endfunction

  function automatic logic m_ready();
    return m_bytes.size() != 8;
  endfunction

  task automatic model_reset();
    m_bytes.delete();
    m_oval  = 1'b0;
    m_left  = 32'h0;
    m_right = 32'h0;
    m_ferr  = 1'b0;
  endtask

  // Advance the model by one clock edge given the inputs present at that edge.
  task automatic model_edge(input logic v, input logic [7:0] d, input logic l, input logic ordy);
    logic free;
    logic ld;
    free   = !m_oval || ordy;
    ld     = 1'b0;
    m_ferr = 1'b0;
    if (v && m_ready()) begin
      m_bytes.push_back(d);
      if (m_bytes.size() == 8) begin
        if (free) ld = 1'b1;
      end else if (l) begin
        m_bytes.delete();
        m_ferr = 1'b1;
      end
    end else if (m_bytes.size() == 8 && free) begin
      ld = 1'b1;
    end
    if (ld) begin
      m_left  = pack_half(m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]);
      m_right = pack_half(m_bytes[4], m_bytes[5], m_bytes[6], m_bytes[7]);
      m_oval  = 1'b1;
      m_bytes.delete();
    end else if (m_oval && ordy) begin
      m_oval = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'(m_ready()));
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(m_oval));
    chk({tag, "_out_left"},  bus.out_left,       m_left);
    chk({tag, "_out_right"}, bus.out_right,      m_right);
    chk({tag, "_frame_err"}, 32'(bus.frame_err), 32'(m_ferr));
  endtask

  // One cycle: drive just after an edge, check at the falling edge, update model at the next edge.
  task automatic cyc(input string tag, input logic v, input logic [7:0] d,
                     input logic l, input logic ordy);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.out_ready = ordy;
    @(negedge clk);
    check_all(tag);
    @(posedge clk);
    model_edge(v, d, l, ordy);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  logic [7:0] blk_a [8];
  logic [7:0] blk_b [8];
  logic [7:0] shortf [4];
  logic       rv, rl, ro;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    model_reset();
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
`ifdef SWAN_LOADER_BE_EN
    blk_a = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h01, 8'h02, 8'h03, 8'h04};
`else
    blk_a = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
`endif
    blk_b  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};
    shortf = '{8'h11, 8'h22, 8'h33, 8'h44};

    // Reset state.
    do_reset();
    @(negedge clk);
    check_all("reset");
    @(posedge clk);
    model_edge(1'b0, 8'h00, 1'b0, 1'b0);
    #1;

    // Single block with out_ready high; fixed expected halves.
    for (int i = 0; i < 8; i++) cyc("t1", 1'b1, blk_a[i], 1'b0, 1'b1);
    chk("t1_valid_now", 32'(bus.out_valid), 32'h1);
    chk("t1_left_const", bus.out_left, 32'h78563412);
`ifdef SWAN_LOADER_BE_EN
    chk("t1_right_const", bus.out_right, 32'h01020304);
`else
    chk("t1_right_const", bus.out_right, 32'hF0DEBC9A);
`endif
    cyc("t1_idle", 1'b0, 8'h00, 1'b0, 1'b1);
    chk("t1_valid_drop", 32'(bus.out_valid), 32'h0);

    // Back-to-back blocks with the consumer stalled, then released.
    for (int i = 0; i < 8; i++) cyc("t2a", 1'b1, blk_a[i], 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc("t2b", 1'b1, blk_b[i], 1'b0, 1'b0);
    chk("t2_ready_low", 32'(bus.in_ready), 32'h0);
    cyc("t2_stall", 1'b1, 8'h55, 1'b0, 1'b0);
    cyc("t2_release", 1'b0, 8'h00, 1'b0, 1'b1);
    chk("t2_valid_kept", 32'(bus.out_valid), 32'h1);
    chk("t2_second_left", bus.out_left, pack_half(blk_b[0], blk_b[1], blk_b[2], blk_b[3]));
    chk("t2_ready_back", 32'(bus.in_ready), 32'h1);
    cyc("t2_drain", 1'b0, 8'h00, 1'b0, 1'b1);

    // Continuous stream, three blocks.
    for (int i = 0; i < 24; i++) cyc("t3", 1'b1, 8'($urandom), 1'b0, 1'b1);
    cyc("t3_drain", 1'b0, 8'h00, 1'b0, 1'b1);

    // Short frame then a full block aligned from byte 0.
    for (int i = 0; i < 4; i++) cyc("t4s", 1'b1, shortf[i], (i == 3), 1'b1);
    chk("t4_ferr_pulse", 32'(bus.frame_err), 32'h1);
    for (int i = 0; i < 8; i++) cyc("t4", 1'b1, blk_b[i], 1'b0, 1'b1);
    chk("t4_left", bus.out_left, pack_half(blk_b[0], blk_b[1], blk_b[2], blk_b[3]));
    cyc("t4_drain", 1'b0, 8'h00, 1'b0, 1'b1);

    // Reset with a held block and five buffered bytes.
    for (int i = 0; i < 8; i++) cyc("t5a", 1'b1, blk_a[i], 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc("t5b", 1'b1, blk_b[i], 1'b0, 1'b0);
    do_reset();
    chk("t5_valid_cleared", 32'(bus.out_valid), 32'h0);
    chk("t5_ready_set", 32'(bus.in_ready), 32'h1);
    for (int i = 0; i < 8; i++) cyc("t5c", 1'b1, blk_b[i], 1'b0, 1'b1);
    cyc("t5_drain", 1'b0, 8'h00, 1'b0, 1'b1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        rv = ($urandom_range(0, 9) < 7);
        rl = ($urandom_range(0, 15) == 0);
        ro = ($urandom_range(0, 9) < 6);
        cyc("rnd", rv, 8'($urandom), rl, ro);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
